// File: rtl/can_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler_pkg
// Shared definitions for the CAN transmit scheduler slice:
//   CAN_DATA_SIZE  - default frame payload width
//   CAN_ID_SIZE    - default frame identifier width (standard 11-bit ID)
//   sched_state_t  - scheduler FSM states
//   sat_inc32      - saturating 32-bit increment used by the optional
//                    statistics counters (CAN_SCHED_STATS_EN)
// -----------------------------------------------------------------------------
package can_tx_scheduler_pkg;

    localparam int CAN_DATA_SIZE = 64;
    localparam int CAN_ID_SIZE   = 11;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        OFFER,
        WAIT_RESULT
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/can_tx_scheduler_prio_select.sv
// -----------------------------------------------------------------------------
// can_prio_select
// Combinational arbiter over the transmit mailboxes. Among the busy mailboxes
// it finds the one with the numerically smallest identifier (highest CAN
// priority); on equal identifiers the lowest mailbox index wins.
// Ports:
//   busy      in   NUM_MBOX            mailbox holds an unsent frame
//   ids       in   NUM_MBOX x ID_SIZE  identifier of every mailbox
//   win_idx   out  $clog2(NUM_MBOX)    index of the winning mailbox
//   any_valid out  1                   at least one mailbox is busy
// -----------------------------------------------------------------------------
module can_prio_select
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MBOX = 4,
    parameter int ID_SIZE  = CAN_ID_SIZE
) (
    input  logic [NUM_MBOX-1:0]              busy,
    input  logic [NUM_MBOX-1:0][ID_SIZE-1:0] ids,
    output logic [$clog2(NUM_MBOX)-1:0]      win_idx,
    output logic                             any_valid
);

    localparam int IDX_W = $clog2(NUM_MBOX);

    logic [ID_SIZE-1:0] best_id;

    // Linear scan from index 0 upward. Only a strictly smaller ID replaces the
    // current candidate, so ties keep the earlier (lower) index.
    always_comb begin
        win_idx   = '0;
        any_valid = 1'b0;
        best_id   = '1;
        for (int i = 0; i < NUM_MBOX; i++) begin
            if (busy[i] && (!any_valid || (ids[i] < best_id))) begin
                win_idx   = IDX_W'(i);
                any_valid = 1'b1;
                best_id   = ids[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler
// Per-node transmit scheduler. Holds NUM_MBOX host mailboxes (ID + payload),
// presents the highest-priority pending frame to one CAN node, retries failed
// frames up to MAX_RETRY attempts and then aborts them.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   load_valid/idx/id/data    host mailbox write
//   load_err                  pulse: write targeted a busy mailbox, dropped
//   mbox_busy                 per-mailbox "holds unsent frame"
//   tx_pending                frame presented to node (OFFER or WAIT_RESULT)
//   data_in_req               node requests the payload
//   Tx_ID, In_packet          identifier / payload of the presented frame
//   tx_ok, tx_fail            node result pulses
//   mbox_done, mbox_abort     one-hot retire pulses
// Optional feature (macro CAN_SCHED_STATS_EN): adds saturating 32-bit
// counters stat_attempts and stat_fails.
// -----------------------------------------------------------------------------
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MBOX  = 4,
    parameter int DATA_SIZE = CAN_DATA_SIZE,
    parameter int ID_SIZE   = CAN_ID_SIZE,
    parameter int MAX_RETRY = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_valid,
    input  logic [$clog2(NUM_MBOX)-1:0] load_idx,
    input  logic [ID_SIZE-1:0]          load_id,
    input  logic [DATA_SIZE-1:0]        load_data,
    output logic                        load_err,
    output logic [NUM_MBOX-1:0]         mbox_busy,
    output logic                        tx_pending,
    input  logic                        data_in_req,
    output logic [ID_SIZE-1:0]          Tx_ID,
    output logic [DATA_SIZE-1:0]        In_packet,
    input  logic                        tx_ok,
    input  logic                        tx_fail,
    output logic [NUM_MBOX-1:0]         mbox_done,
    output logic [NUM_MBOX-1:0]         mbox_abort
`ifdef CAN_SCHED_STATS_EN
    ,
    output logic [31:0]                 stat_attempts,
    output logic [31:0]                 stat_fails
`endif
);

    localparam int IDX_W   = $clog2(NUM_MBOX);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    sched_state_t                           state;
    logic [IDX_W-1:0]                       cur_idx;
    logic [NUM_MBOX-1:0][ID_SIZE-1:0]       mbox_id;
    logic [DATA_SIZE-1:0]                   mbox_data [NUM_MBOX];
    logic [NUM_MBOX-1:0][RETRY_W-1:0]       retry_cnt;

    logic [IDX_W-1:0]   win_idx;
    logic               any_valid;
    logic               load_accept;
    logic               offer_accept;
    logic               ok_accept;
    logic               fail_accept;
    logic [RETRY_W-1:0] retry_next;

    can_prio_select #(
        .NUM_MBOX (NUM_MBOX),
        .ID_SIZE  (ID_SIZE)
    ) u_prio_select (
        .busy      (mbox_busy),
        .ids       (mbox_id),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    // Qualified handshakes: node inputs only count in the state that expects
    // them, and a simultaneous tx_ok/tx_fail is treated as success.
    always_comb begin
        load_accept  = load_valid && !mbox_busy[load_idx];
        offer_accept = (state == OFFER) && data_in_req;
        ok_accept    = (state == WAIT_RESULT) && tx_ok;
        fail_accept  = (state == WAIT_RESULT) && tx_fail && !tx_ok;
        retry_next   = retry_cnt[cur_idx] + 1'b1;
    end

    // Mailbox storage plus scheduler FSM. A load may land in the same cycle
    // another mailbox retires; the in-flight mailbox is busy, so the two
    // writes to mbox_busy never hit the same bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_idx    <= '0;
            mbox_busy  <= '0;
            mbox_id    <= '0;
            retry_cnt  <= '0;
            for (int i = 0; i < NUM_MBOX; i++) begin
                mbox_data[i] <= '0;
            end
            Tx_ID      <= '0;
            In_packet  <= '0;
            tx_pending <= 1'b0;
            load_err   <= 1'b0;
            mbox_done  <= '0;
            mbox_abort <= '0;
        end else begin
            load_err   <= load_valid && mbox_busy[load_idx];
            mbox_done  <= '0;
            mbox_abort <= '0;

            if (load_accept) begin
                mbox_busy[load_idx] <= 1'b1;
                mbox_id[load_idx]   <= load_id;
                mbox_data[load_idx] <= load_data;
                retry_cnt[load_idx] <= '0;
            end

            case (state)
                IDLE: begin
                    if (|mbox_busy) begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    // Frame contents are frozen here; later higher-priority
                    // loads wait for the next SELECT.
                    if (any_valid) begin
                        cur_idx    <= win_idx;
                        Tx_ID      <= mbox_id[win_idx];
                        In_packet  <= mbox_data[win_idx];
                        tx_pending <= 1'b1;
                        state      <= OFFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OFFER: begin
                    if (offer_accept) begin
                        state <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    if (ok_accept) begin
                        mbox_busy[cur_idx] <= 1'b0;
                        mbox_done[cur_idx] <= 1'b1;
                        tx_pending         <= 1'b0;
                        state              <= IDLE;
                    end else if (fail_accept) begin
                        retry_cnt[cur_idx] <= retry_next;
                        if (retry_next == RETRY_W'(MAX_RETRY)) begin
                            mbox_busy[cur_idx]  <= 1'b0;
                            mbox_abort[cur_idx] <= 1'b1;
                        end
                        tx_pending <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAN_SCHED_STATS_EN
    // Attempt/failure statistics, saturating rather than wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_attempts <= '0;
            stat_fails    <= '0;
        end else begin
            if (offer_accept) begin
                stat_attempts <= sat_inc32(stat_attempts);
            end
            if (fail_accept) begin
                stat_fails <= sat_inc32(stat_fails);
            end
        end
    end
`endif

endmodule

// File: tb/tb_can_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_can_tx_scheduler
// Directed self-checking bench for can_tx_scheduler (NUM_MBOX=4, MAX_RETRY=3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_can_tx_scheduler;

    logic        clock;
    logic        reset;
    logic        load_valid;
    logic [1:0]  load_idx;
    logic [10:0] load_id;
    logic [63:0] load_data;
    logic        load_err;
    logic [3:0]  mbox_busy;
    logic        tx_pending;
    logic        data_in_req;
    logic [10:0] Tx_ID;
    logic [63:0] In_packet;
    logic        tx_ok;
    logic        tx_fail;
    logic [3:0]  mbox_done;
    logic [3:0]  mbox_abort;
`ifdef CAN_SCHED_STATS_EN
    logic [31:0] stat_attempts;
    logic [31:0] stat_fails;
`endif

    int passCount  = 0;
    int checkCount = 0;

    can_tx_scheduler #(
        .NUM_MBOX  (4),
        .DATA_SIZE (64),
        .ID_SIZE   (11),
        .MAX_RETRY (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_idx    (load_idx),
        .load_id     (load_id),
        .load_data   (load_data),
        .load_err    (load_err),
        .mbox_busy   (mbox_busy),
        .tx_pending  (tx_pending),
        .data_in_req (data_in_req),
        .Tx_ID       (Tx_ID),
        .In_packet   (In_packet),
        .tx_ok       (tx_ok),
        .tx_fail     (tx_fail),
        .mbox_done   (mbox_done),
        .mbox_abort  (mbox_abort)
`ifdef CAN_SCHED_STATS_EN
        ,
        .stat_attempts (stat_attempts),
        .stat_fails    (stat_fails)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic lv, input logic [1:0] idx,
                                 input logic [10:0] id, input logic [63:0] data);
        load_valid = lv;
        load_idx   = idx;
        load_id    = id;
        load_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Wait (bounded) for the frame to be offered, check it, then accept it
    // so the scheduler moves into WAIT_RESULT.
    task automatic reachOffer(input string tag, input logic [10:0] expId,
                              input logic [63:0] expData);
        int waited = 0;
        while (tx_pending !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checkOutput({tag, " offer_pending"}, 64'(tx_pending), 64'd1);
        checkOutput({tag, " Tx_ID"}, 64'(Tx_ID), 64'(expId));
        checkOutput({tag, " In_packet"}, In_packet, expData);
        data_in_req = 1'b1;
        tick();
        data_in_req = 1'b0;
        checkOutput({tag, " wait_pending"}, 64'(tx_pending), 64'd1);
    endtask

    // Deliver a node result and check the retire pulses.
    task automatic finishFrame(input string tag, input bit ok,
                               input logic [3:0] expDone, input logic [3:0] expAbort);
        if (ok) tx_ok = 1'b1;
        else tx_fail = 1'b1;
        tick();
        tx_ok   = 1'b0;
        tx_fail = 1'b0;
        checkOutput({tag, " mbox_done"}, 64'(mbox_done), 64'(expDone));
        checkOutput({tag, " mbox_abort"}, 64'(mbox_abort), 64'(expAbort));
        checkOutput({tag, " pending_clr"}, 64'(tx_pending), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        data_in_req = 1'b0;
        tx_ok       = 1'b0;
        tx_fail     = 1'b0;
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        tick();
        tick();
        checkOutput("rst busy", 64'(mbox_busy), 64'd0);
        checkOutput("rst pending", 64'(tx_pending), 64'd0);
        checkOutput("rst Tx_ID", 64'(Tx_ID), 64'd0);
        checkOutput("rst In_packet", In_packet, 64'd0);
        checkOutput("rst load_err", 64'(load_err), 64'd0);
        reset = 1'b0;

        // Test 1: single frame, exact 3-cycle load-to-offer latency.
        $display("[TB] test 1: single mailbox send");
        applyStimulus(1'b1, 2'd0, 11'h123, 64'hAAAABBBBCCCC0020);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        checkOutput("t1 busy", 64'(mbox_busy), 64'h1);
        checkOutput("t1 load_err", 64'(load_err), 64'd0);
        checkOutput("t1 idle_pending", 64'(tx_pending), 64'd0);
        tick();
        checkOutput("t1 select_pending", 64'(tx_pending), 64'd0);
        tick();
        checkOutput("t1 offer_pending", 64'(tx_pending), 64'd1);
        reachOffer("t1", 11'h123, 64'hAAAABBBBCCCC0020);
        finishFrame("t1", 1'b1, 4'b0001, 4'b0000);
        checkOutput("t1 busy_clr", 64'(mbox_busy), 64'd0);
        tick();
        checkOutput("t1 done_pulse", 64'(mbox_done), 64'd0);
        checkOutput("t1 Tx_ID_hold", 64'(Tx_ID), 64'h123);

        // Test 2: lower ID wins regardless of load order.
        $display("[TB] test 2: priority by ID");
        applyStimulus(1'b1, 2'd1, 11'h7FF, 64'h1111_0000_0000_0001);
        tick();
        applyStimulus(1'b1, 2'd3, 11'h001, 64'h3333_0000_0000_0003);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        reachOffer("t2a", 11'h001, 64'h3333_0000_0000_0003);
        finishFrame("t2a", 1'b1, 4'b1000, 4'b0000);
        reachOffer("t2b", 11'h7FF, 64'h1111_0000_0000_0001);
        finishFrame("t2b", 1'b1, 4'b0010, 4'b0000);

        // Test 3: equal IDs, lower index wins (loaded in reverse order).
        $display("[TB] test 3: tie break by index");
        applyStimulus(1'b1, 2'd2, 11'h050, 64'h2222_2222_2222_2222);
        tick();
        applyStimulus(1'b1, 2'd0, 11'h050, 64'h0000_0000_0000_0F0F);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        reachOffer("t3a", 11'h050, 64'h0000_0000_0000_0F0F);
        finishFrame("t3a", 1'b1, 4'b0001, 4'b0000);
        reachOffer("t3b", 11'h050, 64'h2222_2222_2222_2222);
        finishFrame("t3b", 1'b1, 4'b0100, 4'b0000);

        // Test 4: three failures abort the mailbox.
        $display("[TB] test 4: retry and abort");
        applyStimulus(1'b1, 2'd2, 11'h010, 64'h4444_4444_0000_0004);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        for (int i = 0; i < 3; i++) begin
            reachOffer("t4", 11'h010, 64'h4444_4444_0000_0004);
            finishFrame("t4", 1'b0, 4'b0000, (i == 2) ? 4'b0100 : 4'b0000);
        end
        checkOutput("t4 busy_clr", 64'(mbox_busy), 64'd0);
        tick();
        tick();
        tick();
        checkOutput("t4 no_reoffer", 64'(tx_pending), 64'd0);

        // Test 5: busy reload rejected, preemption only at next SELECT.
        $display("[TB] test 5: load_err and preemption");
        applyStimulus(1'b1, 2'd1, 11'h200, 64'h5555_0000_0000_0001);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        reachOffer("t5a", 11'h200, 64'h5555_0000_0000_0001);
        applyStimulus(1'b1, 2'd1, 11'h3FF, 64'hDEAD_BEEF_DEAD_BEEF);
        tick();
        checkOutput("t5 load_err", 64'(load_err), 64'd1);
        applyStimulus(1'b1, 2'd0, 11'h000, 64'h5555_0000_0000_0000);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        checkOutput("t5 load_err_pulse", 64'(load_err), 64'd0);
        checkOutput("t5 busy", 64'(mbox_busy), 64'h3);
        checkOutput("t5 Tx_ID_stable", 64'(Tx_ID), 64'h200);
        finishFrame("t5 fail", 1'b0, 4'b0000, 4'b0000);
        checkOutput("t5 busy_after_fail", 64'(mbox_busy), 64'h3);
        reachOffer("t5b", 11'h000, 64'h5555_0000_0000_0000);
        finishFrame("t5b", 1'b1, 4'b0001, 4'b0000);
        reachOffer("t5c", 11'h200, 64'h5555_0000_0000_0001);
        finishFrame("t5c", 1'b1, 4'b0010, 4'b0000);

        // Test 6: reset in the middle of a frame discards everything.
        $display("[TB] test 6: reset during WAIT_RESULT");
        applyStimulus(1'b1, 2'd3, 11'h0AB, 64'h6666_0000_0000_0006);
        tick();
        applyStimulus(1'b0, 2'd0, 11'h000, 64'h0);
        reachOffer("t6", 11'h0AB, 64'h6666_0000_0000_0006);
        reset = 1'b1;
        #1;
        checkOutput("t6 busy", 64'(mbox_busy), 64'd0);
        checkOutput("t6 pending", 64'(tx_pending), 64'd0);
        checkOutput("t6 Tx_ID", 64'(Tx_ID), 64'd0);
        checkOutput("t6 In_packet", In_packet, 64'd0);
`ifdef CAN_SCHED_STATS_EN
        checkOutput("t6 stat_attempts", 64'(stat_attempts), 64'd0);
        checkOutput("t6 stat_fails", 64'(stat_fails), 64'd0);
`endif
        tick();
        reset = 1'b0;
        tx_ok = 1'b1;
        tick();
        tx_ok = 1'b0;
        checkOutput("t6 late_ok_done", 64'(mbox_done), 64'd0);
        checkOutput("t6 late_ok_busy", 64'(mbox_busy), 64'd0);
        tick();
        tick();
        checkOutput("t6 stays_idle", 64'(tx_pending), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
